// File: rtl/elvm_putc_uart_tx_if.sv
// putc handshake between the ELVM CPU (master) and the character output device (slave).
interface elvm_putc_uart_tx_if #(
    parameter int DATA_W = 24
);
    logic              putc_valid;
    logic [DATA_W-1:0] putc_data;
    logic              putc_ready;

    modport master (output putc_valid, output putc_data, input putc_ready);
    modport slave  (input putc_valid, input putc_data, output putc_ready);
endinterface

// File: rtl/elvm_putc_uart_tx.sv
// putc responder: buffers CPU characters in a FIFO and sends each low byte as 8N1 UART.
module elvm_putc_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int DATA_W       = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    elvm_putc_uart_tx_if.slave            putc,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [7:0]        head;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;
    logic              baud_end;

    // Only the character byte is kept; the rest of the CPU word is dropped here.
    logic unused_hi;
    assign unused_hi = ^putc.putc_data[DATA_W-1:8];

    assign putc.putc_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
    assign push            = putc.putc_valid && putc.putc_ready;
    assign fifo_nonempty   = (fifo_level != '0);
    assign baud_end        = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign head            = mem[rd_ptr];
    // The FSM takes a byte when idle, or at the last stop-bit cycle to chain frames.
    assign pop             = fifo_nonempty &&
                             ((state == IDLE) || ((state == STOP) && baud_end));
    assign busy            = (state != IDLE) || fifo_nonempty;

    // FIFO storage; contents need no reset since the pointers qualify them.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= putc.putc_data[7:0];
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // TX framer: tx is registered and set on each state/bit transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud <= '0;
                    tx   <= 1'b1;
                    if (fifo_nonempty) begin
                        shift <= head;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (fifo_nonempty) begin
                            shift <= head;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
